inst_fetch_resp: RTL and testbench

//  Instruction-fetch responder at the far end of the PC interface. Samples the PC, reads the

---
 rtl/inst_fetch_resp_pkg.sv | 23 ++
 rtl/inst_fetch_resp_rom.sv | 31 +++
 rtl/inst_fetch_resp.sv | 135 +++++++++++++
 tb/tb_inst_fetch_resp.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_resp_pkg.sv
// Shared definitions for the instruction-fetch responder: NOP encoding,
// FSM state encoding, wait-counter width and the fetch-address check.
package fetch_pkg;

  // addi x0,x0,0 -- returned on a bad fetch and after reset
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Wait-state counter width; WAIT_STATES must fit without wrapping
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } fetch_state_e;

  // A fetch is bad when it is not word aligned or lies beyond the ROM
  function automatic logic fetch_addr_bad(input logic [31:0] addr,
                                          input int unsigned depth_log2);
    return (addr[1:0] != 2'b00) || ((addr >> (depth_log2 + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/inst_fetch_resp_rom.sv
// Instruction ROM: registered single-port read plus an independent write
// port for boot/debug loading. A read and write to the same word on one edge
// returns the old contents (read-first). Contents are never reset.
module inst_rom #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  i_rd_en,
  input  logic [DEPTH_LOG2-1:0] i_rd_idx,
  output logic [31:0]           o_rd_data,
  input  logic                  i_wr_en,
  input  logic [DEPTH_LOG2-1:0] i_wr_idx,
  input  logic [31:0]           i_wr_data
);

  logic [31:0] r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [31:0] r_rd_data;

  // Write and registered read share the edge; the read sees pre-write data
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_idx];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder. Samples the PC, reads the ROM, waits the
// configured number of cycles and presents the instruction downstream.
//
// Handshake: inst_valid_o/id_ready_i follow strict valid/ready rules. Once
// inst_valid_o is high, inst_o, inst_addr_o and err_o hold steady until a
// cycle with id_ready_i=1 (and no flush) completes the transfer at the edge.
// hold_flag_o tells the PC register that the current pc_i is not taken at
// this edge; whenever it is low the edge captures pc_i as a new fetch.
// flush_i overrides everything: the in-flight fetch is dropped and the next
// cycle starts from IDLE.
module inst_fetch_resp
  import fetch_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 12,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] NOP_INST    = fetch_pkg::NOP_INST
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  pc_i,
  input  logic         flush_i,
  input  logic         id_ready_i,
  input  logic         wr_en_i,
  input  logic [31:0]  wr_addr_i,
  input  logic [31:0]  wr_data_i,
  output logic [31:0]  inst_o,
  output logic [31:0]  inst_addr_o,
  output logic         inst_valid_o,
  output logic         err_o,
  output logic         hold_flag_o,
  output fetch_state_e dbg_state_o
);

  // The counter is only WAIT_CNT_W bits wide and must not wrap
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("inst_fetch_resp: WAIT_STATES must be in 0..15");
  end

  localparam logic [WAIT_CNT_W-1:0] LP_WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);
  localparam logic [WAIT_CNT_W-1:0] LP_CNT_ONE   = WAIT_CNT_W'(1);

  fetch_state_e          r_state;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic [31:0]           r_addr;
  logic                  r_valid;
  logic                  r_err;
  logic                  r_nop_sel;

  logic                  w_accept;
  logic                  w_bad;
  logic [31:0]           w_rom_rdata;
  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic [DEPTH_LOG2-1:0] w_wr_idx;
  logic                  w_unused_wr_bits;

  // A new PC is taken from IDLE, or from RESP in the same edge the current
  // instruction is handed over; a flush blocks both.
  always_comb begin
    w_accept = 1'b0;
    if (!flush_i) begin
      w_accept = (r_state == ST_IDLE) || ((r_state == ST_RESP) && id_ready_i);
    end
  end

  assign w_bad            = fetch_addr_bad(pc_i, DEPTH_LOG2);
  assign w_rd_idx         = pc_i[DEPTH_LOG2+1:2];
  assign w_wr_idx         = wr_addr_i[DEPTH_LOG2+1:2];
  assign w_unused_wr_bits = ^{wr_addr_i[31:DEPTH_LOG2+2], wr_addr_i[1:0]};

  inst_rom #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_rom (
    .clk       (clk),
    .i_rd_en   (w_accept),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rom_rdata),
    .i_wr_en   (wr_en_i),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data (wr_data_i)
  );

  // Fetch FSM: flush first, then accept a PC or count down wait states
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_addr    <= 32'd0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_nop_sel <= 1'b1;
    end else if (flush_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_RESP: begin
          if (w_accept) begin
            r_addr    <= pc_i;
            r_err     <= w_bad;
            r_nop_sel <= w_bad;
            if (WAIT_STATES == 0) begin
              r_state <= ST_RESP;
              r_valid <= 1'b1;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= LP_WAIT_LOAD;
              r_valid <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - LP_CNT_ONE;
          if (r_cnt == LP_CNT_ONE) begin
            r_state <= ST_RESP;
            r_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // ROM data is already registered at the accept edge; bad fetches show NOP
  assign inst_o       = r_nop_sel ? NOP_INST : w_rom_rdata;
  assign inst_addr_o  = r_addr;
  assign inst_valid_o = r_valid;
  assign err_o        = r_err;
  assign hold_flag_o  = !w_accept;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Bench for inst_fetch_resp. Instance 0 has no wait states, instance 1 has
// two. The driver plays the PC register; expected responses go into a
// per-instance queue when a PC is taken, and the monitor pops and compares
// on every completed transfer.
module tb_inst_fetch_resp;
  import fetch_pkg::*;

  localparam logic [31:0] I_A = 32'hA000_0001;
  localparam logic [31:0] I_B = 32'hB000_0002;
  localparam logic [31:0] I_C = 32'hC000_0003;
  localparam logic [31:0] I_D = 32'hD000_0004;
  localparam logic [31:0] I_J = 32'h0400_0016;
  localparam logic [31:0] I_E = 32'hE000_0005;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst     [2];
  logic [31:0]  pc      [2];
  logic         flush   [2];
  logic         rdy     [2];
  logic         wr_en   [2];
  logic [31:0]  wr_addr [2];
  logic [31:0]  wr_data [2];
  logic [31:0]  inst    [2];
  logic [31:0]  iaddr   [2];
  logic         valid   [2];
  logic         err     [2];
  logic         hold    [2];
  fetch_state_e dbg     [2];

  inst_fetch_resp #(.DEPTH_LOG2(12), .WAIT_STATES(0)) u_dut_w0 (
    .clk(clk), .rst(rst[0]), .pc_i(pc[0]), .flush_i(flush[0]),
    .id_ready_i(rdy[0]), .wr_en_i(wr_en[0]), .wr_addr_i(wr_addr[0]),
    .wr_data_i(wr_data[0]), .inst_o(inst[0]), .inst_addr_o(iaddr[0]),
    .inst_valid_o(valid[0]), .err_o(err[0]), .hold_flag_o(hold[0]),
    .dbg_state_o(dbg[0])
  );

  inst_fetch_resp #(.DEPTH_LOG2(12), .WAIT_STATES(2)) u_dut_w2 (
    .clk(clk), .rst(rst[1]), .pc_i(pc[1]), .flush_i(flush[1]),
    .id_ready_i(rdy[1]), .wr_en_i(wr_en[1]), .wr_addr_i(wr_addr[1]),
    .wr_data_i(wr_data[1]), .inst_o(inst[1]), .inst_addr_o(iaddr[1]),
    .inst_valid_o(valid[1]), .err_o(err[1]), .hold_flag_o(hold[1]),
    .dbg_state_o(dbg[1])
  );

  // ---------------- scoreboard state ----------------
  int         n_pass  = 0;
  int         n_total = 0;
  int         n_xfer [2];
  logic [64:0] exp_q0[$];
  logic [64:0] exp_q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic push_exp(input int d, input logic [64:0] v);
    if (d == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  // ---------------- monitor ----------------
  always begin
    @(negedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      if (rst[d] && valid[d] && rdy[d] && !flush[d]) begin
        logic [64:0] a;
        logic [64:0] e;
        logic        empty;
        a = {err[d], iaddr[d], inst[d]};
        n_xfer[d]++;
        empty = (d == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
        n_total++;
        if (empty) begin
          $display("FAIL xfer_dut%0d: got err/addr/inst %h, expected no transfer", d, a);
        end else begin
          e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          if (a === e) n_pass++;
          else $display("FAIL xfer_dut%0d: got err/addr/inst %h, expected %h", d, a, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rom_write(input int d, input logic [31:0] a, input logic [31:0] v);
    wr_en[d]   = 1'b1;
    wr_addr[d] = a;
    wr_data[d] = v;
    @(negedge clk);
    wr_en[d]   = 1'b0;
  endtask

  // Present a PC, wait until it is taken, then step past the taking edge
  task automatic issue(input int d, input logic [31:0] a, input logic [31:0] ei,
                       input logic ee, input bit push);
    int n;
    n        = 0;
    flush[d] = 1'b0;
    pc[d]    = a;
    #1;
    while (hold[d] && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (hold[d]) begin
      n_total++;
      $display("FAIL issue_timeout_dut%0d: hold still 1 after %0d cycles, required 0", d, n);
    end else if (push) begin
      push_exp(d, {ee, a, ei});
    end
    @(negedge clk);
  endtask

  // Jump away and park in IDLE with flush held high
  task automatic flush_idle(input int d);
    flush[d] = 1'b1;
    @(negedge clk);
    #1;
    check($sformatf("flush_valid_dut%0d", d), 32'(valid[d]), 32'd0);
    check($sformatf("flush_state_dut%0d", d), 32'(dbg[d]), 32'(ST_IDLE));
  endtask

  task automatic wait_valid(input int d, input string name);
    int n;
    n = 0;
    #1;
    while (!valid[d] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!valid[d]) begin
      n_total++;
      $display("FAIL %s: valid still 0 after %0d cycles, required 1", name, n);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int x0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; pc[d] = 32'd0; flush[d] = 1'b0; rdy[d] = 1'b1;
      wr_en[d] = 1'b0; wr_addr[d] = 32'd0; wr_data[d] = 32'd0; n_xfer[d] = 0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_valid_dut%0d", d), 32'(valid[d]), 32'd0);
      check($sformatf("rst_hold_dut%0d", d),  32'(hold[d]),  32'd0);
      check($sformatf("rst_inst_dut%0d", d),  inst[d],       NOP);
      check($sformatf("rst_addr_dut%0d", d),  iaddr[d],      32'd0);
      check($sformatf("rst_err_dut%0d", d),   32'(err[d]),   32'd0);
      check($sformatf("rst_state_dut%0d", d), 32'(dbg[d]),   32'(ST_IDLE));
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      flush[d] = 1'b1;
      rst[d]   = 1'b1;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      rom_write(d, 32'h00, I_A);
      rom_write(d, 32'h04, I_B);
      rom_write(d, 32'h08, I_C);
      rom_write(d, 32'h0C, I_D);
      rom_write(d, 32'h40, I_J);
    end

    // 1: no wait states, back-to-back fetches, one response per cycle
    issue(0, 32'h0, I_A, 1'b0, 1'b1);
    #1; check("t1_valid_0", 32'(valid[0]), 32'd1); check("t1_hold_0", 32'(hold[0]), 32'd0);
    issue(0, 32'h4, I_B, 1'b0, 1'b1);
    #1; check("t1_valid_1", 32'(valid[0]), 32'd1); check("t1_hold_1", 32'(hold[0]), 32'd0);
    issue(0, 32'h8, I_C, 1'b0, 1'b1);
    #1; check("t1_valid_2", 32'(valid[0]), 32'd1); check("t1_hold_2", 32'(hold[0]), 32'd0);
    issue(0, 32'hC, I_D, 1'b0, 1'b1);
    #1; check("t1_valid_3", 32'(valid[0]), 32'd1); check("t1_hold_3", 32'(hold[0]), 32'd0);
    issue(0, 32'h0, I_A, 1'b0, 1'b0);
    flush_idle(0);

    // 2: two wait states; valid appears on the third cycle after the accept
    issue(1, 32'h0, I_A, 1'b0, 1'b1);
    n = 1;
    #1;
    while (!valid[1] && n < 10) begin
      check("t2_hold_wait", 32'(hold[1]), 32'd1);
      @(negedge clk);
      #1;
      n++;
    end
    check("t2_latency", 32'(n), 32'd3);
    issue(1, 32'hC, I_D, 1'b0, 1'b0);
    flush_idle(1);

    // 3: downstream stall for four cycles, then a single transfer
    rdy[1] = 1'b0;
    issue(1, 32'h4, I_B, 1'b0, 1'b1);
    wait_valid(1, "t3_valid");
    for (int i = 0; i < 4; i++) begin
      check("t3_hold",  32'(hold[1]),  32'd1);
      check("t3_valid", 32'(valid[1]), 32'd1);
      check("t3_inst",  inst[1],       I_B);
      check("t3_addr",  iaddr[1],      32'h4);
      @(negedge clk);
      #1;
    end
    x0 = n_xfer[1];
    rdy[1] = 1'b1;
    issue(1, 32'hC, I_D, 1'b0, 1'b0);
    flush_idle(1);
    check("t3_xfer_once", 32'(n_xfer[1] - x0), 32'd1);

    // 4: flush while waiting; the old fetch vanishes, the jump target is served
    issue(1, 32'h0, I_A, 1'b0, 1'b0);
    flush[1] = 1'b1;
    pc[1]    = 32'h40;
    @(negedge clk);
    #1;
    check("t4_valid_after_flush", 32'(valid[1]), 32'd0);
    check("t4_state_after_flush", 32'(dbg[1]), 32'(ST_IDLE));
    issue(1, 32'h40, I_J, 1'b0, 1'b1);
    wait_valid(1, "t4_valid");
    check("t4_addr", iaddr[1], 32'h40);
    issue(1, 32'hC, I_D, 1'b0, 1'b0);
    flush_idle(1);

    // 5: misaligned and out-of-range fetches return NOP with err; err clears
    issue(1, 32'h0000_0002, NOP, 1'b1, 1'b1);
    issue(1, 32'h0001_0000, NOP, 1'b1, 1'b1);
    issue(1, 32'h0000_0008, I_C, 1'b0, 1'b1);
    issue(1, 32'hC, I_D, 1'b0, 1'b0);
    flush_idle(1);

    // 6: asynchronous reset mid-wait, then same-edge write/read of word 2
    issue(1, 32'h0, I_A, 1'b0, 1'b0);
    rst[1] = 1'b0;
    #1;
    check("t6_rst_valid", 32'(valid[1]), 32'd0);
    check("t6_rst_hold",  32'(hold[1]),  32'd0);
    check("t6_rst_state", 32'(dbg[1]),   32'(ST_IDLE));
    check("t6_rst_inst",  inst[1],       NOP);
    @(negedge clk);
    flush[1] = 1'b1;
    rst[1]   = 1'b1;
    @(negedge clk);
    wr_en[1]   = 1'b1;
    wr_addr[1] = 32'h8;
    wr_data[1] = I_E;
    issue(1, 32'h8, I_C, 1'b0, 1'b1);
    wr_en[1] = 1'b0;
    issue(1, 32'h8, I_E, 1'b0, 1'b1);
    issue(1, 32'hC, I_D, 1'b0, 1'b0);
    flush_idle(1);

    repeat (2) @(negedge clk);
    check("q0_empty", 32'(exp_q0.size()), 32'd0);
    check("q1_empty", 32'(exp_q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
